lifo_stack: RTL and testbench

Parametrised LIFO stack for the multi-cycle CPU datapath. It generalises the original 8-bit/128-entry operand stack to arbitrary width and depth, and adds:
- full/empty/count status
- overflow and underflow detection with a sticky error
- atomic replace-top when push and pop are asserted together
- an optional swap-top-two operation

It sits between the controller FSM and the ALU operand path; the controller issues one stack command per cycle.

---
 rtl/lifo_stack_pkg.sv | 17 +
 rtl/lifo_stack_regfile.sv | 40 ++++
 rtl/lifo_stack.sv | 186 ++++++++++++++++++
 tb/tb_lifo_stack.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared types for the LIFO operand stack: command priority encoding and count sizing.
package lifo_stack_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_REPLACE,
    CMD_PUSH,
    CMD_POP,
    CMD_SWAP,
    CMD_TOS
  } cmd_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_stack_regfile.sv
// WIDTH x DEPTH storage with asynchronous reads of the top (and second) entry.
// With LIFO_STACK_SWAP_EN defined, a second read/write port supports swap-top-two.
module lifo_stack_regfile
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
`ifdef LIFO_STACK_SWAP_EN
  input  logic             we2,
  input  logic [AW-1:0]    waddr2,
  input  logic [WIDTH-1:0] wdata2,
  input  logic [AW-1:0]    rd_sec_addr,
  output logic [WIDTH-1:0] rd_sec,
`endif
  input  logic [AW-1:0]    rd_top_addr,
  output logic [WIDTH-1:0] rd_top
);

  // Storage is deliberately not reset; validity is tracked by the count register.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
`ifdef LIFO_STACK_SWAP_EN
    if (we2) mem_q[waddr2] <= wdata2;
`endif
  end

  assign rd_top = mem_q[rd_top_addr];
`ifdef LIFO_STACK_SWAP_EN
  assign rd_sec = mem_q[rd_sec_addr];
`endif

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO operand stack with status, overflow/underflow detection and replace-top.
// Optional swap-top-two command is enabled by defining LIFO_STACK_SWAP_EN.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic             swap,
  input  logic             clr_err,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             err_q, err_d;

  cmd_e             cmd;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    push_addr;
  logic [WIDTH-1:0] rd_top;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

  // Clamp the top pointer at 0 so an empty stack never indexes outside the array.
  assign top_addr  = empty ? '0 : AW'(count_q - CNT_ONE);
  assign push_addr = AW'(count_q);

`ifdef LIFO_STACK_SWAP_EN
  logic             we2;
  logic [AW-1:0]    sec_addr;
  logic [WIDTH-1:0] rd_sec;

  assign sec_addr = (count_q < CNT_W'(2)) ? '0 : AW'(count_q - CNT_W'(2));
`else
  logic unused_swap;
  assign unused_swap = swap;
`endif

  always_comb begin
    cmd = CMD_NONE;
    if (push && pop)  cmd = CMD_REPLACE;
    else if (push)    cmd = CMD_PUSH;
    else if (pop)     cmd = CMD_POP;
`ifdef LIFO_STACK_SWAP_EN
    else if (swap)    cmd = CMD_SWAP;
`endif
    else if (tos)     cmd = CMD_TOS;
  end

  always_comb begin
    count_d  = count_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    we       = 1'b0;
    waddr    = top_addr;
    wdata    = d_in;
`ifdef LIFO_STACK_SWAP_EN
    we2      = 1'b0;
`endif
    case (cmd)
      CMD_REPLACE: begin
        we = 1'b1;
        if (empty) begin
          count_d = CNT_ONE;
          udf_d   = 1'b1;
        end else begin
          dout_d   = rd_top;
          dvalid_d = 1'b1;
        end
      end
      CMD_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = push_addr;
          count_d = count_q + CNT_ONE;
        end
      end
      CMD_POP: begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          dout_d   = rd_top;
          dvalid_d = 1'b1;
          count_d  = count_q - CNT_ONE;
        end
      end
`ifdef LIFO_STACK_SWAP_EN
      CMD_SWAP: begin
        if (count_q >= CNT_W'(2)) begin
          we    = 1'b1;
          wdata = rd_sec;
          we2   = 1'b1;
        end else begin
          udf_d = 1'b1;
        end
      end
`endif
      CMD_TOS: begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          dout_d   = rd_top;
          dvalid_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A fault arriving with clr_err wins so it is never lost.
    err_d = (err_q & ~clr_err) | ovf_d | udf_d;
  end

  lifo_stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk         (clk),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
`ifdef LIFO_STACK_SWAP_EN
    .we2         (we2),
    .waddr2      (sec_addr),
    .wdata2      (rd_top),
    .rd_sec_addr (sec_addr),
    .rd_sec      (rd_sec),
`endif
    .rd_top_addr (top_addr),
    .rd_top      (rd_top)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      err_q    <= err_d;
    end
  end

  assign count   = count_q;
  assign d_out   = dout_q;
  assign d_valid = dvalid_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign err     = err_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed plus random bench for lifo_stack (DEPTH=4); a behavioural stack model feeds an expectation queue.
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef LIFO_STACK_SWAP_EN
  localparam bit SWAP_ON = 1'b1;
`else
  localparam bit SWAP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             tos = 1'b0;
  logic             swap = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;
  logic             err;

  always #5 clk = ~clk;

  lifo_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .swap    (swap),
    .clr_err (clr_err),
    .d_out   (d_out),
    .d_valid (d_valid),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf),
    .err     (err)
  );

  typedef struct {
    string      tag;
    logic [7:0] dout;
    logic       dv;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_stack[$];
  logic [7:0] m_dout = '0;
  logic       m_err = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input logic o, input logic u, input logic v);
    exp_t e;
    e.tag   = tag;
    e.dout  = m_dout;
    e.dv    = v;
    e.cnt   = 3'(m_stack.size());
    e.full  = (m_stack.size() == DEPTH);
    e.empty = (m_stack.size() == 0);
    e.ovf   = o;
    e.udf   = u;
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic model(input string tag, input logic p, input logic po, input logic t,
                       input logic s, input logic c, input logic [7:0] din);
    logic       o, u, v;
    logic [7:0] tmp;
    int         n;
    o = 1'b0; u = 1'b0; v = 1'b0;
    n = m_stack.size();
    if (p && po) begin
      if (n > 0) begin
        m_dout = m_stack[n-1];
        m_stack[n-1] = din;
        v = 1'b1;
      end else begin
        m_stack.push_back(din);
        u = 1'b1;
      end
    end else if (p) begin
      if (n < DEPTH) m_stack.push_back(din);
      else o = 1'b1;
    end else if (po) begin
      if (n > 0) begin
        m_dout = m_stack.pop_back();
        v = 1'b1;
      end else u = 1'b1;
    end else if (s && SWAP_ON) begin
      if (n >= 2) begin
        tmp = m_stack[n-1];
        m_stack[n-1] = m_stack[n-2];
        m_stack[n-2] = tmp;
      end else u = 1'b1;
    end else if (t) begin
      if (n > 0) begin
        m_dout = m_stack[n-1];
        v = 1'b1;
      end else u = 1'b1;
    end
    m_err = (m_err & ~c) | o | u;
    push_exp(tag, o, u, v);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, "count",   32'(count),   32'(e.cnt));
      chk(e.tag, "full",    32'(full),    32'(e.full));
      chk(e.tag, "empty",   32'(empty),   32'(e.empty));
      chk(e.tag, "d_valid", 32'(d_valid), 32'(e.dv));
      chk(e.tag, "d_out",   32'(d_out),   32'(e.dout));
      chk(e.tag, "ovf",     32'(ovf),     32'(e.ovf));
      chk(e.tag, "udf",     32'(udf),     32'(e.udf));
      chk(e.tag, "err",     32'(err),     32'(e.err));
    end
  endtask

  task automatic step(input string tag, input logic p, input logic po, input logic t,
                      input logic s, input logic c, input logic [7:0] din);
    @(negedge clk);
    rst = 1'b1;
    push = p; pop = po; tos = t; swap = s; clr_err = c; d_in = din;
    model(tag, p, po, t, s, c, din);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    push = 1'b0; pop = 1'b0; tos = 1'b0; swap = 1'b0; clr_err = 1'b0;
    m_stack.delete();
    m_dout = '0;
    m_err  = 1'b0;
    push_exp(tag, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out();
  endtask

  //                 tag     push  pop   tos   swap  clr
  initial begin
    do_reset("reset0");
    do_reset("reset1");

    step("push11", 1, 0, 0, 0, 0, 8'h11);
    step("push22", 1, 0, 0, 0, 0, 8'h22);
    step("push33", 1, 0, 0, 0, 0, 8'h33);
    step("pop33",  0, 1, 0, 0, 0, 8'h00);
    chk("pop33", "anchor", 32'(d_out), 32'h33);
    step("pop22",  0, 1, 0, 0, 0, 8'h00);
    step("pop11",  0, 1, 0, 0, 0, 8'h00);
    chk("pop11", "anchor", 32'(d_out), 32'h11);
    step("idle",   0, 0, 0, 0, 0, 8'h00);

    for (int i = 1; i <= 4; i++) step("fill", 1, 0, 0, 0, 0, 8'(i));
    step("ovf55",  1, 0, 0, 0, 0, 8'h55);
    chk("ovf55", "anchor_ovf", 32'(ovf), 32'h1);
    step("pop4",   0, 1, 0, 0, 0, 8'h00);
    chk("pop4", "anchor", 32'(d_out), 32'h04);
    step("push_tos_prio", 1, 0, 1, 0, 0, 8'h66);
    step("pop66",  0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step("drain", 0, 1, 0, 0, 0, 8'h00);

    do_reset("reset2");
    step("udf_pop", 0, 1, 0, 0, 0, 8'h00);
    step("udf_tos", 0, 0, 1, 0, 0, 8'h00);
    chk("udf_tos", "anchor_dout", 32'(d_out), 32'h00);
    step("clr",     0, 0, 0, 0, 1, 8'h00);
    step("udf_clr", 0, 1, 0, 0, 1, 8'h00);
    step("clr2",    0, 0, 0, 0, 1, 8'h00);

    step("pushA",   1, 0, 0, 0, 0, 8'h0A);
    step("pushB",   1, 0, 0, 0, 0, 8'h0B);
    step("replC",   1, 1, 0, 0, 0, 8'h0C);
    chk("replC", "anchor", 32'(d_out), 32'h0B);
    step("tosC",    0, 0, 1, 0, 0, 8'h00);
    step("pop",     0, 1, 0, 0, 0, 8'h00);
    step("pop",     0, 1, 0, 0, 0, 8'h00);
    step("repl_empty", 1, 1, 0, 0, 0, 8'h77);
    step("pop77",   0, 1, 0, 0, 0, 8'h00);
    step("clr3",    0, 0, 0, 0, 1, 8'h00);

    step("push1",   1, 0, 0, 0, 0, 8'h01);
    step("push2",   1, 0, 0, 0, 0, 8'h02);
    step("swap",    0, 0, 0, 1, 0, 8'h00);
    step("pop_a",   0, 1, 0, 0, 0, 8'h00);
    step("pop_b",   0, 1, 0, 0, 0, 8'h00);
    step("push7",   1, 0, 0, 0, 0, 8'h07);
    step("swap1",   0, 0, 0, 1, 0, 8'h00);
    step("swap_tos", 0, 0, 1, 1, 0, 8'h00);
    step("pop7",    0, 1, 0, 0, 0, 8'h00);

    step("pushR1",  1, 0, 0, 0, 0, 8'h91);
    step("pushR2",  1, 0, 0, 0, 0, 8'h92);
    step("pushR3",  1, 0, 0, 0, 0, 8'h93);
    do_reset("mid_reset");
    step("tos_after_rst", 0, 0, 1, 0, 0, 8'h00);

    for (int i = 0; i < 300; i++) begin
      step("rnd",
           logic'($urandom_range(0, 9) < 5),
           logic'($urandom_range(0, 9) < 4),
           logic'($urandom_range(0, 4) == 0),
           logic'($urandom_range(0, 4) == 0),
           logic'($urandom_range(0, 7) == 0),
           8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
